// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between a load/store client and mem_access_unit.
// master = CPU/bridge side, slave = mem_access_unit side.
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 10
`endif

interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = `RAM_ADDR_WIDTH
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH+1:0] req_addr;
    logic [31:0]           req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mem_access_unit.sv
// Byte-addressed load/store initiator for a word-addressed, byte-enabled, 1-cycle-latency RAM.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of truncating the offset.
`ifndef RAM_ADDR_WIDTH
`define RAM_ADDR_WIDTH 10
`endif

module mem_access_unit #(
    parameter int ADDR_WIDTH = `RAM_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_access_unit_if.slave      bus,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_din,
    output logic [3:0]            ram_we,
    input  logic [31:0]           ram_dout
);
    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       uns;
        logic [1:0] off;
    } req_t;

    state_t      state, state_nxt;
    req_t        req_q;
    logic        hs, illegal;
    logic [1:0]  off_in;
    logic [3:0]  we_in;
    logic [31:0] din_in, ext;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign hs = bus.req_valid & bus.req_ready;

    always_comb begin
        illegal = (bus.req_size == 2'b11);
`ifdef MEM_MISALIGN_TRAP_EN
        if (bus.req_size == 2'b01 && bus.req_addr[0])          illegal = 1'b1;
        if (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00) illegal = 1'b1;
`endif
    end

    // Offending low address bits are dropped here; trapped requests never reach the RAM anyway.
    always_comb begin
        off_in = 2'b00;
        we_in  = 4'b1111;
        din_in = bus.req_wdata;
        case (bus.req_size)
            2'b00: begin
                off_in = bus.req_addr[1:0];
                we_in  = 4'b0001 << off_in;
                din_in = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                off_in = {bus.req_addr[1], 1'b0};
                we_in  = 4'b0011 << off_in;
                din_in = {2{bus.req_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = illegal ? RESP : ISSUE;
            ISSUE:   state_nxt = req_q.we ? RESP : CAPTURE;
            CAPTURE: state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = (state == IDLE);
        bus.rsp_valid = (state == RESP);
    end

    always_comb begin
        byte_v = ram_dout[{req_q.off, 3'b000} +: 8];
        half_v = ram_dout[{req_q.off[1], 4'b0000} +: 16];
        case (req_q.size)
            2'b00:   ext = {{24{~req_q.uns & byte_v[7]}}, byte_v};
            2'b01:   ext = {{16{~req_q.uns & half_v[15]}}, half_v};
            default: ext = ram_dout;
        endcase
    end

    // ram_we is loaded on the handshake edge and self-clears, so it is live only during ISSUE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q         <= '0;
            ram_addr      <= '0;
            ram_din       <= '0;
            ram_we        <= '0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            ram_we <= '0;
            if (hs) begin
                req_q         <= '{we: bus.req_we, size: bus.req_size, uns: bus.req_unsigned, off: off_in};
                bus.rsp_err   <= illegal;
                bus.rsp_rdata <= '0;
                if (!illegal) begin
                    ram_addr <= bus.req_addr[ADDR_WIDTH+1:2];
                    if (bus.req_we) begin
                        ram_we  <= we_in;
                        ram_din <= din_in;
                    end
                end
            end
            if (state == CAPTURE) bus.rsp_rdata <= ext;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: scoreboard of expected responses against a behavioural RAM.
module tb_mem_access_unit;
    localparam int AW = 8;
    localparam int BW = AW + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_din, ram_dout;
    logic [3:0]    ram_we;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_WIDTH(AW)) bus();

    mem_access_unit #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) mem[ram_addr][8*i +: 8] <= ram_din[8*i +: 8];
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic          we;
        logic [1:0]    size;
        logic          uns;
        logic [BW-1:0] addr;
        logic [31:0]   wdata;
        logic [31:0]   rdata;
        logic          err;
        logic [4:0]    lat;
        logic [3:0]    xwe;
        logic [31:0]   xdin;
    } txn_t;

    txn_t        sb[$];
    int          checks = 0, failures = 0;
    logic [AW-1:0] iss_addr;
    logic [3:0]  iss_we;
    logic [31:0] iss_din, got_rdata;
    logic        got_err;
    int          hs_cyc, we_seen, lat;

    function automatic txn_t mk(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [BW-1:0] addr, input logic [31:0] wdata,
                                input logic [31:0] rdata, input logic err, input int l,
                                input logic [3:0] xwe, input logic [31:0] xdin);
        txn_t t;
        t.we = we; t.size = sz; t.uns = uns; t.addr = addr; t.wdata = wdata;
        t.rdata = rdata; t.err = err; t.lat = 5'(l); t.xwe = xwe; t.xdin = xdin;
        return t;
    endfunction

    // Drives one handshake, snapshots the ISSUE cycle and scrambles req_* afterwards.
    task automatic send(input txn_t t);
        int n = 0;
        while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
        if (!bus.req_ready) begin
            checks++; failures++;
            $display("FAIL send_wait req_ready got=0 exp=1");
        end
        bus.req_valid = 1'b1; bus.req_we = t.we; bus.req_size = t.size;
        bus.req_unsigned = t.uns; bus.req_addr = t.addr; bus.req_wdata = t.wdata;
        @(negedge clk);
        hs_cyc = cyc;
        bus.req_valid = 1'b0;
        bus.req_we = 1'($urandom); bus.req_size = 2'($urandom); bus.req_unsigned = 1'($urandom);
        bus.req_addr = BW'($urandom); bus.req_wdata = $urandom;
        iss_addr = ram_addr; iss_we = ram_we; iss_din = ram_din;
        we_seen = (ram_we != 4'h0) ? 1 : 0;
        sb.push_back(t);
    endtask

    // Waits (bounded) for rsp_valid, records latency in cycles after the handshake, then accepts.
    task automatic get_rsp();
        lat = 1;
        while (!bus.rsp_valid && lat < 20) begin
            @(negedge clk); lat++;
            if (ram_we != 4'h0) we_seen++;
        end
        got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL reset req_ready got=%b exp=1", bus.req_ready); end
        checks++; if ({bus.rsp_valid, bus.rsp_err} !== 2'b00) begin failures++; $display("FAIL reset rsp_valid/err got=%b%b exp=00", bus.rsp_valid, bus.rsp_err); end
        checks++; if (bus.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset rsp_rdata got=%h exp=0", bus.rsp_rdata); end
        checks++; if ({ram_addr, ram_din, ram_we} !== '0) begin failures++; $display("FAIL reset ram got addr=%h din=%h we=%h exp=0", ram_addr, ram_din, ram_we); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_store_load();
        txn_t tbl[$];
        txn_t e;
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 10'h10, 32'hDEADBEEF, 32'h0,        1'b0, 2, 4'hF, 32'hDEADBEEF));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 10'h10, 32'h0,        32'h0,        1'b0, 2, 4'hF, 32'h0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 10'h13, 32'h00000080, 32'h0,        1'b0, 2, 4'h8, 32'h80808080));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 10'h13, 32'h0,        32'hFFFFFF80, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 10'h13, 32'h0,        32'h00000080, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h10, 32'h0,        32'h80000000, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 10'h22, 32'hFFFF1234, 32'h0,        1'b0, 2, 4'hC, 32'h12341234));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 10'h22, 32'h0,        32'h00001234, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 10'h22, 32'h00008001, 32'h0,        1'b0, 2, 4'hC, 32'h80018001));
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 10'h22, 32'h0,        32'hFFFF8001, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 10'h22, 32'h0,        32'h00008001, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 10'h21, 32'hFFFFFF5A, 32'h0,        1'b0, 2, 4'h2, 32'h5A5A5A5A));
        tbl.push_back(mk(1'b0, 2'd0, 1'b1, 10'h21, 32'h0,        32'h0000005A, 1'b0, 3, 4'h0, 32'h0));
        foreach (tbl[i]) begin
            send(tbl[i]); get_rsp(); e = sb.pop_front();
            checks++; if (got_rdata !== e.rdata) begin failures++; $display("FAIL store_load[%0d] rdata got=%h exp=%h", i, got_rdata, e.rdata); end
            checks++; if (got_err !== e.err) begin failures++; $display("FAIL store_load[%0d] err got=%b exp=%b", i, got_err, e.err); end
            checks++; if (lat != int'(e.lat)) begin failures++; $display("FAIL store_load[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (we_seen != ((e.we && !e.err) ? 1 : 0)) begin failures++; $display("FAIL store_load[%0d] we_cycles got=%0d", i, we_seen); end
            if (!e.err) begin
                checks++; if (iss_addr !== e.addr[BW-1:2]) begin failures++; $display("FAIL store_load[%0d] ram_addr got=%h exp=%h", i, iss_addr, e.addr[BW-1:2]); end
            end
            if (e.we && !e.err) begin
                checks++; if ({iss_we, iss_din} !== {e.xwe, e.xdin}) begin failures++; $display("FAIL store_load[%0d] we/din got=%h/%h exp=%h/%h", i, iss_we, iss_din, e.xwe, e.xdin); end
            end
        end
    endtask

    task automatic test_misalign();
        txn_t tbl[$];
        txn_t e;
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 10'h20, 32'h8001C3C4, 32'h0,        1'b0, 2, 4'hF, 32'h8001C3C4));
`ifdef MEM_MISALIGN_TRAP_EN
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 10'h21, 32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h22, 32'h0,        32'h0,        1'b1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 10'h23, 32'h00007777, 32'h0,        1'b1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 10'h22, 32'h11111111, 32'h0,        1'b1, 1, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h20, 32'h0,        32'h8001C3C4, 1'b0, 3, 4'h0, 32'h0));
`else
        tbl.push_back(mk(1'b0, 2'd1, 1'b0, 10'h21, 32'h0,        32'hFFFFC3C4, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h22, 32'h0,        32'h8001C3C4, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 10'h23, 32'h00007777, 32'h0,        1'b0, 2, 4'hC, 32'h77777777));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h20, 32'h0,        32'h7777C3C4, 1'b0, 3, 4'h0, 32'h0));
`endif
        foreach (tbl[i]) begin
            send(tbl[i]); get_rsp(); e = sb.pop_front();
            checks++; if (got_rdata !== e.rdata) begin failures++; $display("FAIL misalign[%0d] rdata got=%h exp=%h", i, got_rdata, e.rdata); end
            checks++; if (got_err !== e.err) begin failures++; $display("FAIL misalign[%0d] err got=%b exp=%b", i, got_err, e.err); end
            checks++; if (lat != int'(e.lat)) begin failures++; $display("FAIL misalign[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
            checks++; if (we_seen != ((e.we && !e.err) ? 1 : 0)) begin failures++; $display("FAIL misalign[%0d] we_cycles got=%0d", i, we_seen); end
            if (e.we && !e.err) begin
                checks++; if ({iss_we, iss_din} !== {e.xwe, e.xdin}) begin failures++; $display("FAIL misalign[%0d] we/din got=%h/%h exp=%h/%h", i, iss_we, iss_din, e.xwe, e.xdin); end
            end
        end
    endtask

    task automatic test_illegal_stall();
        txn_t e;
        bus.rsp_ready = 1'b0;
        send(mk(1'b1, 2'd3, 1'b0, 10'h10, 32'hFFFFFFFF, 32'h0, 1'b1, 1, 4'h0, 32'h0));
        for (int k = 0; k < 5; k++) begin
            checks++;
            if ({bus.rsp_valid, bus.rsp_err, bus.req_ready, ram_we, bus.rsp_rdata} !== {1'b1, 1'b1, 1'b0, 4'h0, 32'h0}) begin
                failures++;
                $display("FAIL stall[%0d] valid/err/ready/we/rdata got=%b/%b/%b/%h/%h exp=1/1/0/0/0", k,
                         bus.rsp_valid, bus.rsp_err, bus.req_ready, ram_we, bus.rsp_rdata);
            end
            @(negedge clk);
        end
        get_rsp(); e = sb.pop_front();
        checks++; if (got_err !== e.err) begin failures++; $display("FAIL illegal err got=%b exp=%b", got_err, e.err); end
        checks++; if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin failures++; $display("FAIL illegal after_accept valid/ready got=%b%b exp=01", bus.rsp_valid, bus.req_ready); end
        send(mk(1'b0, 2'd2, 1'b0, 10'h10, 32'h0, 32'h80000000, 1'b0, 3, 4'h0, 32'h0));
        get_rsp(); e = sb.pop_front();
        checks++; if (got_rdata !== e.rdata) begin failures++; $display("FAIL illegal no_write rdata got=%h exp=%h", got_rdata, e.rdata); end
    endtask

    task automatic test_back_to_back();
        txn_t tbl[$];
        txn_t e;
        int prev_hs = 0, prev_lat = 0;
        tbl.push_back(mk(1'b1, 2'd2, 1'b0, 10'h40, 32'hA0A1A2A3, 32'h0,        1'b0, 2, 4'hF, 32'hA0A1A2A3));
        tbl.push_back(mk(1'b1, 2'd1, 1'b0, 10'h46, 32'h0000BEEF, 32'h0,        1'b0, 2, 4'hC, 32'hBEEFBEEF));
        tbl.push_back(mk(1'b1, 2'd0, 1'b0, 10'h48, 32'h0000007F, 32'h0,        1'b0, 2, 4'h1, 32'h7F7F7F7F));
        tbl.push_back(mk(1'b0, 2'd2, 1'b0, 10'h40, 32'h0,        32'hA0A1A2A3, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd1, 1'b1, 10'h46, 32'h0,        32'h0000BEEF, 1'b0, 3, 4'h0, 32'h0));
        tbl.push_back(mk(1'b0, 2'd0, 1'b0, 10'h48, 32'h0,        32'h0000007F, 1'b0, 3, 4'h0, 32'h0));
        foreach (tbl[i]) begin
            send(tbl[i]);
            if (i > 0) begin
                checks++; if (hs_cyc - prev_hs != prev_lat + 1) begin failures++; $display("FAIL b2b[%0d] issue_gap got=%0d exp=%0d", i, hs_cyc - prev_hs, prev_lat + 1); end
            end
            prev_hs = hs_cyc;
            get_rsp(); e = sb.pop_front();
            prev_lat = int'(e.lat);
            checks++; if (got_rdata !== e.rdata) begin failures++; $display("FAIL b2b[%0d] rdata got=%h exp=%h", i, got_rdata, e.rdata); end
            checks++; if (lat != int'(e.lat)) begin failures++; $display("FAIL b2b[%0d] latency got=%0d exp=%0d", i, lat, e.lat); end
        end
    endtask

    task automatic test_reset_mid_issue();
        txn_t e;
        send(mk(1'b1, 2'd2, 1'b0, 10'h30, 32'h11223344, 32'h0, 1'b0, 2, 4'hF, 32'h11223344));
        get_rsp(); e = sb.pop_front();
        send(mk(1'b1, 2'd2, 1'b0, 10'h30, 32'h55667788, 32'h0, 1'b0, 2, 4'hF, 32'h55667788));
        e = sb.pop_front();
        checks++; if (ram_we !== 4'hF) begin failures++; $display("FAIL rst_mid issue ram_we got=%h exp=f", ram_we); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if ({ram_we, bus.req_ready, bus.rsp_valid} !== {4'h0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL rst_mid async we/ready/valid got=%h/%b/%b exp=0/1/0", ram_we, bus.req_ready, bus.rsp_valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if ({bus.req_ready, bus.rsp_valid, bus.rsp_err} !== 3'b100) begin
            failures++; $display("FAIL rst_mid release ready/valid/err got=%b%b%b exp=100", bus.req_ready, bus.rsp_valid, bus.rsp_err);
        end
        send(mk(1'b0, 2'd2, 1'b0, 10'h30, 32'h0, 32'h11223344, 1'b0, 3, 4'h0, 32'h0));
        get_rsp(); e = sb.pop_front();
        checks++; if (got_rdata !== e.rdata) begin failures++; $display("FAIL rst_mid word_unchanged got=%h exp=%h", got_rdata, e.rdata); end
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'd0; bus.req_unsigned = 1'b0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;
        test_reset();
        test_store_load();
        test_misalign();
        test_illegal_stall();
        test_back_to_back();
        test_reset_mid_issue();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog sim_time got=expired exp=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
